// File: rtl/w_mem_read_sequencer.sv
// Weight-region read sequencer: walks rows of the weight SRAM wrapper, repeats the
// region a programmed number of times and streams each row out through a 2-entry buffer.
module w_mem_read_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ADDR_STEP  = 4,
    parameter int unsigned ROWS_WIDTH = 12,
    parameter int unsigned REP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ROWS_WIDTH-1:0] cfg_num_rows,
    input  logic [REP_WIDTH-1:0]  cfg_num_repeats,
    input  logic                  wr_busy,
    output logic                  rd_enable,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  w_last_row,
    output logic                  w_last_all,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_q, addr_q;
    logic [ROWS_WIDTH-1:0] rows_q, row_cnt;
    logic [REP_WIDTH-1:0]  reps_q, rep_cnt;
    logic                  infl_q, infl_lr_q, infl_la_q;
    logic [DATA_WIDTH-1:0] ent_data [2];
    logic                  ent_lr   [2];
    logic                  ent_la   [2];
    logic                  head_q;
    logic [1:0]            occ_q, occ_nxt, fill;
    logic                  done_q, done_nxt;
    logic                  push, pop, zero_job;
    logic                  issue_last_row, issue_last_all;

    assign push           = infl_q;
    assign pop            = (occ_q != 2'd0) && w_ready;
    assign occ_nxt        = occ_q + {1'b0, push} - {1'b0, pop};
    // The entry leaving this cycle counts as free so back-to-back reads sustain one row per cycle.
    assign fill           = occ_q + {1'b0, infl_q} - {1'b0, pop};
    assign zero_job       = (cfg_num_rows == '0) || (cfg_num_repeats == '0);
    assign issue_last_row = (row_cnt == rows_q - ROWS_WIDTH'(1));
    assign issue_last_all = issue_last_row && (rep_cnt == reps_q - REP_WIDTH'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !zero_job) state_nxt = ISSUE;
            ISSUE:   if (rd_enable && issue_last_all) state_nxt = DRAIN;
            DRAIN:   if (!infl_q && occ_nxt == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_comb begin
        rd_enable = (state == ISSUE) && !wr_busy && (fill < 2'd2);
        rd_addr   = addr_q;
        done_nxt  = !clear && (((state == IDLE) && start && zero_job) ||
                               ((state == DRAIN) && !infl_q && occ_nxt == 2'd0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q    <= '0;
            addr_q    <= '0;
            rows_q    <= '0;
            reps_q    <= '0;
            row_cnt   <= '0;
            rep_cnt   <= '0;
            infl_q    <= 1'b0;
            infl_lr_q <= 1'b0;
            infl_la_q <= 1'b0;
            head_q    <= 1'b0;
            occ_q     <= '0;
            done_q    <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                ent_data[i] <= '0;
                ent_lr[i]   <= 1'b0;
                ent_la[i]   <= 1'b0;
            end
        end else if (clear) begin
            infl_q <= 1'b0;
            head_q <= 1'b0;
            occ_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_nxt;
            if (state == IDLE && start) begin
                base_q  <= cfg_base_addr;
                addr_q  <= cfg_base_addr;
                rows_q  <= cfg_num_rows;
                reps_q  <= cfg_num_repeats;
                row_cnt <= '0;
                rep_cnt <= '0;
            end else if (rd_enable) begin
                if (issue_last_row) begin
                    row_cnt <= '0;
                    addr_q  <= base_q;
                    rep_cnt <= rep_cnt + REP_WIDTH'(1);
                end else begin
                    row_cnt <= row_cnt + ROWS_WIDTH'(1);
                    addr_q  <= addr_q + ADDR_WIDTH'(ADDR_STEP);
                end
            end
            infl_q    <= rd_enable;
            infl_lr_q <= issue_last_row;
            infl_la_q <= issue_last_all;
            if (push) begin
                ent_data[head_q ^ occ_q[0]] <= rd_data;
                ent_lr[head_q ^ occ_q[0]]   <= infl_lr_q;
                ent_la[head_q ^ occ_q[0]]   <= infl_la_q;
            end
            if (pop) head_q <= ~head_q;
            occ_q <= occ_nxt;
        end
    end

    assign w_data     = ent_data[head_q];
    assign w_last_row = ent_lr[head_q];
    assign w_last_all = ent_la[head_q];
    assign w_valid    = (occ_q != 2'd0);
    assign busy       = (state != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_w_mem_read_sequencer.sv
// Bench for w_mem_read_sequencer: job table plus scoreboard of expected reads and rows,
// with hand-written clear and async-reset sequences.
module tb_w_mem_read_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, clear, wr_busy, w_ready;
    logic [15:0] cfg_base_addr;
    logic [11:0] cfg_num_rows;
    logic [7:0]  cfg_num_repeats;
    logic        rd_enable;
    logic [15:0] rd_addr;
    logic [31:0] rd_data;
    logic [31:0] w_data;
    logic        w_valid, w_last_row, w_last_all, busy, done;

    w_mem_read_sequencer #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .ADDR_STEP(4), .ROWS_WIDTH(12), .REP_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .cfg_base_addr(cfg_base_addr), .cfg_num_rows(cfg_num_rows),
        .cfg_num_repeats(cfg_num_repeats), .wr_busy(wr_busy),
        .rd_enable(rd_enable), .rd_addr(rd_addr), .rd_data(rd_data),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .w_last_row(w_last_row), .w_last_all(w_last_all), .busy(busy), .done(done)
    );

    typedef struct {
        logic [31:0] data;
        logic        lr;
        logic        la;
    } row_t;

    typedef struct {
        logic [15:0] base;
        logic [11:0] rows;
        logic [7:0]  reps;
        logic [3:0]  rdy;
        int          bat;
        int          blen;
        int          exp_beats;
        int          done_lat;
    } job_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          beat_n  = 0;
    int          last_all_cyc = -1;
    int          iss_n = 0;
    int          pop_n = 0;
    bit          mon_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic [15:0] exp_addr_q[$];
    row_t        exp_row_q[$];
    job_t        jobs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    // SRAM model: one cycle of read latency
    always @(posedge clk) if (rd_enable) rd_data <= mem_word(rd_addr);

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            exp_addr_q.delete();
            exp_row_q.delete();
            iss_n = 0;
            pop_n = 0;
            stall_prev = 1'b0;
        end else begin
            chk("outstanding_le2", longint'(iss_n - pop_n <= 2), 1);
            if (stall_prev) begin
                chk("stall_valid_held", w_valid, 1);
                chk("stall_data_held", w_data, prev_data);
            end
            if (wr_busy) chk("no_read_while_wr_busy", rd_enable, 0);
            if (rd_enable) begin
                chk("read_expected", longint'(exp_addr_q.size() != 0), 1);
                if (exp_addr_q.size() != 0) chk("rd_addr", rd_addr, exp_addr_q.pop_front());
            end
            if (w_valid && w_ready) begin
                beat_n++;
                chk("row_expected", longint'(exp_row_q.size() != 0), 1);
                if (exp_row_q.size() != 0) begin
                    row_t er;
                    er = exp_row_q.pop_front();
                    chk("w_data", w_data, er.data);
                    chk("w_last_row", w_last_row, er.lr);
                    chk("w_last_all", w_last_all, er.la);
                    if (er.la) last_all_cyc = cyc;
                end
            end
            stall_prev = w_valid && !w_ready;
            prev_data  = w_data;
            iss_n += int'(rd_enable);
            pop_n += int'(w_valid && w_ready);
        end
    end

    task automatic run_job(input job_t j);
        int s, first_v, done_cyc, b0;
        logic [15:0] a;
        for (int r = 0; r < int'(j.reps); r++) begin
            for (int i = 0; i < int'(j.rows); i++) begin
                a = j.base + 16'(i * 4);
                exp_addr_q.push_back(a);
                exp_row_q.push_back('{mem_word(a), i == int'(j.rows) - 1,
                                      (i == int'(j.rows) - 1) && (r == int'(j.reps) - 1)});
            end
        end
        b0 = beat_n; first_v = -1; done_cyc = -1;
        cfg_base_addr = j.base; cfg_num_rows = j.rows; cfg_num_repeats = j.reps;
        w_ready = j.rdy[0]; wr_busy = 1'b0; start = 1'b1;
        s = cyc;
        tick;
        start = 1'b0;
        for (int k = 1; k < 600 && done_cyc < 0; k++) begin
            if (w_valid && first_v < 0) first_v = cyc;
            if (done) done_cyc = cyc;
            if (done_cyc < 0) begin
                w_ready = j.rdy[k % 4];
                wr_busy = (j.blen > 0) && (k >= j.bat) && (k < j.bat + j.blen);
                tick;
            end
        end
        wr_busy = 1'b0; w_ready = 1'b1;
        chk("done_seen", longint'(done_cyc >= 0), 1);
        chk("beat_count", beat_n - b0, j.exp_beats);
        chk("rows_outstanding", exp_row_q.size(), 0);
        chk("reads_outstanding", exp_addr_q.size(), 0);
        if (j.done_lat > 0) chk("done_latency", done_cyc - s, j.done_lat);
        if (j.exp_beats == 0) begin
            chk("zero_job_no_valid", first_v, -1);
        end else begin
            chk("first_valid_latency", first_v - s, 3);
            chk("done_after_last_all", done_cyc - last_all_cyc, 1);
        end
        tick;
        chk("done_one_cycle", done, 0);
        chk("idle_after_job", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

    initial begin
        jobs[0] = '{16'h0040, 12'd3, 8'd2, 4'b1111, 0, 0,  6, 9};
        jobs[1] = '{16'h0100, 12'd8, 8'd1, 4'b1001, 0, 0,  8, 0};
        jobs[2] = '{16'h0200, 12'd6, 8'd2, 4'b1111, 4, 5, 12, 0};
        jobs[3] = '{16'hFFFC, 12'd2, 8'd1, 4'b1111, 0, 0,  2, 5};
        jobs[4] = '{16'h1234, 12'd5, 8'd3, 4'b1011, 2, 3, 15, 0};
        jobs[5] = '{16'h0080, 12'd0, 8'd4, 4'b1111, 0, 0,  0, 1};
        jobs[6] = '{16'h0090, 12'd4, 8'd0, 4'b1111, 0, 0,  0, 1};

        reset = 1'b0; start = 1'b0; clear = 1'b0; wr_busy = 1'b0; w_ready = 1'b1;
        cfg_base_addr = '0; cfg_num_rows = '0; cfg_num_repeats = '0;
        repeat (2) tick;
        chk("reset_outputs", {rd_enable, rd_addr, w_data, w_valid, w_last_row, w_last_all, busy, done}, 0);
        reset = 1'b1;
        tick;
        mon_en = 1'b1;
        tick;

        for (int t = 0; t < 7; t++) run_job(jobs[t]);

        // clear with one row buffered and one in flight; a simultaneous start is ignored
        mon_en = 1'b0;
        repeat (2) tick;
        w_ready = 1'b0;
        cfg_base_addr = 16'h0300; cfg_num_rows = 12'd8; cfg_num_repeats = 8'd1;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (2) tick;
        chk("pre_clear_valid", w_valid, 1);
        chk("pre_clear_busy", busy, 1);
        clear = 1'b1; start = 1'b1; cfg_base_addr = 16'h0500; cfg_num_rows = 12'd4;
        tick;
        clear = 1'b0; start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_clear_quiet", {w_valid, busy, done, rd_enable}, 0);
            tick;
        end
        w_ready = 1'b1;
        mon_en = 1'b1;
        tick;
        run_job('{16'h0500, 12'd4, 8'd1, 4'b1111, 0, 0, 4, 0});

        // asynchronous reset mid-job
        mon_en = 1'b0;
        repeat (2) tick;
        cfg_base_addr = 16'h0700; cfg_num_rows = 12'd8; cfg_num_repeats = 8'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1'b0;
        #1 chk("async_reset_outputs",
               {rd_enable, rd_addr, w_data, w_valid, w_last_row, w_last_all, busy, done}, 0);
        tick;
        reset = 1'b1;
        tick;
        mon_en = 1'b1;
        tick;
        run_job('{16'h0800, 12'd3, 8'd1, 4'b1111, 0, 0, 3, 0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
